// File: rtl/ldo_power_sequencer_if.sv
// Handshake bundle between the power controller / LDO analog pins and the
// LDO enable sequencer. The master drives the request and carries the
// comparator output. The slave (the sequencer) drives the enables and status.
interface ldo_power_sequencer_if;
    logic       req_on;
    logic       pgood;
    logic       ldo_en;
    logic       ldo_enb;
    logic       ready;
    logic       fault;
    logic       busy;
    logic [2:0] state_o;

    modport master (
        output req_on, pgood,
        input  ldo_en, ldo_enb, ready, fault, busy, state_o
    );

    modport slave (
        input  req_on, pgood,
        output ldo_en, ldo_enb, ready, fault, busy, state_o
    );
endinterface

// File: rtl/ldo_power_sequencer.sv
// Enable sequencer for the 3.3V->1.8V LDO. It ramps the rail and waits a fixed
// settle time. It then qualifies the synchronized power-good, discharges on
// shutdown and latches faults.
// Optional feature: define LDO_SEQ_RETRY_EN to re-ramp automatically after a
// fault, up to RETRY_MAX times, while req_on stays high.
// All outputs decode from the state register only. There is no
// input-to-output combinational path.
module ldo_power_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int OFF_CYCLES    = 8,
    parameter int RETRY_MAX     = 3,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    ldo_power_sequencer_if.slave  bus
);
    // Parameter sanity: both hold times must fit in the shared down-counter.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (1 << CNT_W) - 1 ||
        OFF_CYCLES < 1 || OFF_CYCLES > (1 << CNT_W) - 1 || RETRY_MAX < 0) begin : g_bad_param
        $error("ldo_power_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RAMP  = 3'd1,
        S_ON    = 3'd2,
        S_DIS   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             pgood_m, pgood_s;
    logic             en, ready, fault, busy;

`ifdef LDO_SEQ_RETRY_EN
    localparam int            RW        = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    logic [RW-1:0] retry_cnt;
    logic          retry_inc, retry_clr;
`endif

    assign cnt_zero = (cnt == '0);

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pgood_m <= 1'b0;
            pgood_s <= 1'b0;
        end else begin
            pgood_m <= bus.pgood;
            pgood_s <= pgood_m;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_OFF;
        else         state <= state_nxt;
    end

    // Shared down-counter: loaded on state entry, then counts down and holds at 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        cnt <= '0;
        else if (cnt_load)  cnt <= cnt_load_val;
        else if (!cnt_zero) cnt <= cnt - 1'b1;
    end

`ifdef LDO_SEQ_RETRY_EN
    // Retry counter: cleared in OFF and on a good ramp, saturates at RETRY_MAX.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                   retry_cnt <= '0;
        else if (retry_clr)                            retry_cnt <= '0;
        else if (retry_inc && retry_cnt < RETRY_LIM)   retry_cnt <= retry_cnt + 1'b1;
    end
`endif

    // Next-state and counter-load decision. req_on=0 always wins over pgood.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = SETTLE_LOAD;
`ifdef LDO_SEQ_RETRY_EN
        retry_inc    = 1'b0;
        retry_clr    = 1'b0;
`endif
        case (state)
            S_OFF: begin
`ifdef LDO_SEQ_RETRY_EN
                retry_clr = 1'b1;
`endif
                if (bus.req_on) begin
                    state_nxt    = S_RAMP;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LOAD;
                end
            end
            S_RAMP: begin
                if (!bus.req_on) begin
                    state_nxt    = S_DIS;
                    cnt_load     = 1'b1;
                    cnt_load_val = OFF_LOAD;
                end else if (cnt_zero) begin
                    if (pgood_s) begin
                        state_nxt = S_ON;
`ifdef LDO_SEQ_RETRY_EN
                        retry_clr = 1'b1;
`endif
                    end else begin
                        state_nxt    = S_FAULT;
                        cnt_load     = 1'b1;
                        cnt_load_val = OFF_LOAD;
                    end
                end
            end
            S_ON: begin
                if (!bus.req_on) begin
                    state_nxt    = S_DIS;
                    cnt_load     = 1'b1;
                    cnt_load_val = OFF_LOAD;
                end else if (!pgood_s) begin
                    state_nxt    = S_FAULT;
                    cnt_load     = 1'b1;
                    cnt_load_val = OFF_LOAD;
                end
            end
            S_DIS: begin
                // req_on is ignored here so the LDO cannot short-cycle.
                if (cnt_zero) state_nxt = S_OFF;
            end
            S_FAULT: begin
                if (cnt_zero) begin
                    if (!bus.req_on) begin
                        state_nxt = S_OFF;
                    end
`ifdef LDO_SEQ_RETRY_EN
                    else if (retry_cnt < RETRY_LIM) begin
                        state_nxt    = S_RAMP;
                        cnt_load     = 1'b1;
                        cnt_load_val = SETTLE_LOAD;
                        retry_inc    = 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = S_OFF;
        endcase
    end

    // Output decode, purely from the state register.
    always_comb begin
        en    = (state == S_RAMP) || (state == S_ON);
        ready = (state == S_ON);
        fault = (state == S_FAULT);
        busy  = (state == S_RAMP) || (state == S_DIS);
    end

    assign bus.ldo_en  = en;
    assign bus.ldo_enb = ~en;
    assign bus.ready   = ready;
    assign bus.fault   = fault;
    assign bus.busy    = busy;
    assign bus.state_o = state;
endmodule

// File: tb/tb_ldo_power_sequencer.sv
// Randomized lock-step bench for ldo_power_sequencer. A phase/age model
// predicts the full output vector each cycle. Directed checks cover start-up
// latency, dropout latency and asynchronous reset mid-ON.
module tb_ldo_power_sequencer;
    localparam int SETTLE = 8;
    localparam int OFFC   = 4;
    localparam int RETRY  = 2;

    logic clk = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_err = 0;

    ldo_power_sequencer_if bus();

    ldo_power_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .OFF_CYCLES   (OFFC),
        .RETRY_MAX    (RETRY),
        .CNT_W        (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Model: phase (0 off,1 ramp,2 on,3 discharge,4 fault), cycles spent in the
    // phase, retries used, and pgood history for the two-cycle synchronizer delay.
    int m_mode, m_age, m_retry;
    bit p1, p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_vec(input int m);
        logic e;
        e = (m == 1) || (m == 2);
        return {3'(m), e, ~e, (m == 2), (m == 4), (m == 1) || (m == 3)};
    endfunction

    function automatic logic [7:0] got_vec();
        return {bus.state_o, bus.ldo_en, bus.ldo_enb, bus.ready, bus.fault, bus.busy};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_retry = 0; p1 = 0; p2 = 0;
    endtask

    task automatic model_edge();
        bit ps;
        bit rq;
        ps = p2;
        p2 = p1;
        p1 = bus.pgood;
        rq = bus.req_on;
        case (m_mode)
            0: begin
                m_retry = 0;
                if (rq) begin m_mode = 1; m_age = 0; end
            end
            1: begin
                if (!rq) begin m_mode = 3; m_age = 0; end
                else if (m_age == SETTLE - 1) begin
                    m_age = 0;
                    if (ps) begin m_mode = 2; m_retry = 0; end
                    else m_mode = 4;
                end else m_age++;
            end
            2: begin
                if (!rq) begin m_mode = 3; m_age = 0; end
                else if (!ps) begin m_mode = 4; m_age = 0; end
            end
            3: begin
                if (m_age == OFFC - 1) m_mode = 0;
                else m_age++;
            end
            4: begin
                if (m_age < OFFC - 1) m_age++;
                else if (!rq) m_mode = 0;
`ifdef LDO_SEQ_RETRY_EN
                else if (m_retry < RETRY) begin m_retry++; m_mode = 1; m_age = 0; end
`endif
            end
            default: m_mode = 0;
        endcase
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (resetn) model_edge();
        else        model_reset();
        @(negedge clk);
        chk("cycle", 32'(got_vec()), 32'(exp_vec(m_mode)));
    endtask

    initial begin
        int n;
        int len;
        model_reset();
        resetn     = 1'b0;
        bus.req_on = 1'b0;
        bus.pgood  = 1'b0;
        #2;
        chk("reset_state", 32'(got_vec()), 32'h08);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Start-up: ready expected after SETTLE+1 edges.
        bus.req_on = 1'b1;
        bus.pgood  = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.ready && n < 50);
        chk("ramp_latency", 32'(n), 32'(SETTLE + 1));

        // Asynchronous reset mid-ON, checked without a clock edge.
        for (int i = 0; i < 3; i++) step();
        #2 resetn = 1'b0;
        #1 chk("async_reset", 32'(got_vec()), 32'h08);
        model_reset();
        @(negedge clk);
        chk("reset_hold", 32'(got_vec()), 32'h08);
        resetn = 1'b1;

        // Start-up again, then a dropout with req_on held.
        n = 0;
        do begin step(); n++; end while (!bus.ready && n < 50);
        chk("ramp_latency2", 32'(n), 32'(SETTLE + 1));
        bus.pgood = 1'b0;
        n = 0;
        do begin step(); n++; end while (bus.state_o != 3'd4 && n < 50);
        chk("dropout_latency", 32'(n), 32'd3);

        // Fault with req_on held long (sticky or retry path), then release.
        for (int i = 0; i < 70; i++) step();
        bus.req_on = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Randomized segments of held req_on/pgood levels, with single-cycle glitches.
        for (int s = 0; s < 120; s++) begin
            bus.req_on = ($urandom_range(0, 3) != 0);
            bus.pgood  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) bus.req_on = ~bus.req_on;
                if ($urandom_range(0, 15) == 0) bus.pgood  = ~bus.pgood;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
